// File: rtl/test_monitor_pkg.sv
// Shared state encoding and default bench addresses for the end-of-test monitor.
package test_monitor_pkg;

  typedef enum logic [2:0] {
    ST_RST     = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  localparam logic [31:0] TOHOST_ADDR_DEF  = 32'h0000_1000;
  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h0000_1008;

endpackage

// File: rtl/test_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/test_monitor.sv
// Bench end-of-test monitor: holds Core in reset, then decides PASS/FAIL/TIMEOUT from tohost stores.
// Define TEST_MONITOR_CONSOLE_EN to add a one-cycle console character tap.
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter int              RST_CYCLES     = 4,
  parameter int              TIMEOUT_CYCLES = 10000,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(TOHOST_ADDR_DEF),
  parameter int              CNT_W          = 32
`ifdef TEST_MONITOR_CONSOLE_EN
  ,
  parameter logic [XLEN-1:0] CONSOLE_ADDR   = XLEN'(CONSOLE_ADDR_DEF)
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             restart_i,
  input  logic             dmem_we_i,
  input  logic [XLEN-1:0]  dmem_addr_i,
  input  logic [XLEN-1:0]  dmem_wdata_i,
  input  logic             retire_i,
  output logic             core_rst_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [XLEN-2:0]  fail_code_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [CNT_W-1:0] instret_o,
  output logic [2:0]       state_o
`ifdef TEST_MONITOR_CONSOLE_EN
  ,
  output logic             console_valid_o,
  output logic [7:0]       console_char_o
`endif
);

  localparam int               RC_W     = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
  logic            pass_q, pass_d;
  logic            timeout_q, timeout_d;
  logic [XLEN-2:0] fail_code_q, fail_code_d;

  logic is_run, is_term, exit_wr, cyc_inc, ret_inc, cnt_clr;

  assign is_run  = (state_q == ST_RUN);
  assign is_term = (state_q == ST_PASS) || (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
  assign exit_wr = dmem_we_i && (dmem_addr_i == TOHOST_ADDR) && dmem_wdata_i[0];

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = '0;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    fail_code_d = fail_code_q;
    case (state_q)
      ST_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        // An exit store takes priority over the timeout boundary.
        if (exit_wr) begin
          if (dmem_wdata_i == XLEN'(1)) begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
          end else begin
            state_d     = ST_FAIL;
            fail_code_d = dmem_wdata_i[XLEN-1:1];
          end
        end else if (cycle_count_o == TO_LAST) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
        end
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        if (restart_i) begin
          state_d     = ST_RST;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          fail_code_d = '0;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_RST;
      rst_cnt_q   <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      fail_code_q <= fail_code_d;
    end
  end

  // The transition edge out of RUN does not count as a run cycle; retires still do.
  assign cyc_inc = is_run && (state_d == ST_RUN);
  assign ret_inc = is_run && retire_i;
  assign cnt_clr = is_term && restart_i;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .inc_i (cyc_inc),
    .cnt_o (cycle_count_o)
  );

  sat_counter #(.W(CNT_W)) u_instret_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .inc_i (ret_inc),
    .cnt_o (instret_o)
  );

`ifdef TEST_MONITOR_CONSOLE_EN
  logic       con_vld_q, con_vld_d;
  logic [7:0] con_chr_q, con_chr_d;

  always_comb begin
    con_vld_d = is_run && (state_d == ST_RUN) && dmem_we_i && (dmem_addr_i == CONSOLE_ADDR);
    con_chr_d = con_vld_d ? dmem_wdata_i[7:0] : 8'h00;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      con_vld_q <= 1'b0;
      con_chr_q <= 8'h00;
    end else begin
      con_vld_q <= con_vld_d;
      con_chr_q <= con_chr_d;
    end
  end

  assign console_valid_o = con_vld_q;
  assign console_char_o  = con_chr_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      assert (RST_CYCLES >= 1 && TIMEOUT_CYCLES >= 1)
        else $error("test_monitor: RST_CYCLES and TIMEOUT_CYCLES must be >= 1");
      assert ($clog2(TIMEOUT_CYCLES + 1) <= CNT_W)
        else $error("test_monitor: TIMEOUT_CYCLES must fit in CNT_W bits");
    end
  end

  assign core_rst_o  = !is_run;
  assign done_o      = is_term;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign fail_code_o = fail_code_q;
  assign state_o     = state_q;

endmodule

// File: doc/test_monitor.md
Name: test_monitor

Overview:
- Parametrised successor to the fixed-time core bench run; all bench end-of-test control moves into one synthesizable block.
- Sits beside Core in the bench. Drives Core's reset for a configurable number of cycles, then watches Core's data-memory store port for a "tohost" exit write.
- Decides PASS / FAIL(code) / TIMEOUT and counts run cycles and retired instructions. The bench waits on done_o instead of a fixed delay.

Parameters:
- XLEN, 32, data/address width of the monitored store port
- RST_CYCLES, 4, cycles core_rst_o stays asserted after rst_i releases (>=1)
- TIMEOUT_CYCLES, 10000, maximum RUN cycles before TIMEOUT (>=1)
- TOHOST_ADDR, 32'h0000_1000, store address that terminates the test
- CNT_W, 32, width of cycle and instret counters

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous reset, active-low
- restart_i  in  1  one-cycle pulse; re-runs the test from a terminal state
- dmem_we_i  in  1  Core data-memory write enable
- dmem_addr_i  in  XLEN  Core data-memory write address
- dmem_wdata_i  in  XLEN  Core data-memory write data
- retire_i  in  1  Core retired one instruction this cycle
- core_rst_o  out  1  reset to Core, active-high
- done_o  out  1  test finished (PASS, FAIL or TIMEOUT)
- pass_o  out  1  finished with PASS
- timeout_o  out  1  finished with TIMEOUT
- fail_code_o  out  XLEN-1  riscv-tests failing test number; 0 unless FAIL
- cycle_count_o  out  CNT_W  RUN cycles elapsed
- instret_o  out  CNT_W  instructions retired during RUN
- state_o  out  3  current state encoding (package enum)

Behaviour:
- Reset (rst_i==0 at an edge) sets: state=ST_RST, rst counter=0, core_rst_o=1, done_o=0, pass_o=0, timeout_o=0, fail_code_o=0, cycle_count_o=0, instret_o=0.
- ST_RST:
  - core_rst_o=1. Rst counter increments each cycle.
  - Once RST_CYCLES cycles have elapsed after rst_i goes high, go to ST_RUN. Core therefore sees exactly RST_CYCLES reset-high edges after release.
- ST_RUN:
  - core_rst_o=0. cycle_count_o increments by 1 each cycle, saturating at all-ones.
  - instret_o increments when retire_i==1, saturating.
  - Exit write = dmem_we_i==1 && dmem_addr_i==TOHOST_ADDR && dmem_wdata_i[0]==1.
    - wdata==1: go to ST_PASS.
    - Otherwise: go to ST_FAIL and latch fail_code_o=dmem_wdata_i[XLEN-1:1].
  - Tohost writes with wdata[0]==0 are ignored; bench syscalls are out of scope.
  - When cycle_count_o==TIMEOUT_CYCLES-1 and there is no exit write that cycle, go to ST_TIMEOUT.
  - An exit write in the same cycle as the timeout boundary wins: PASS or FAIL, not TIMEOUT.
  - Counters do not include the exit cycle's increment. They freeze at their value before the transition edge, except that retire_i in the exit cycle is still counted.
- Terminal states (ST_PASS, ST_FAIL, ST_TIMEOUT):
  - done_o=1. pass_o / timeout_o / fail_code_o are held. core_rst_o=1, so Core is frozen.
  - Counters are held. dmem and retire inputs are ignored.
- restart_i:
  - In a terminal state: next state ST_RST; all counters, fail_code_o and flags clear to their reset values.
  - In ST_RST or ST_RUN: ignored.
- Outputs are registered, except core_rst_o and done_o, which decode the current state combinationally.
- rst_i asserted mid-RUN: immediate return to reset values next edge; Core reset is reasserted.
- Assertions (sim only):
  - RST_CYCLES>=1 and TIMEOUT_CYCLES>=1.
  - TIMEOUT_CYCLES < 2**CNT_W.

Optional Feature:
- Macro TEST_MONITOR_CONSOLE_EN.
- With it:
  - Extra parameter CONSOLE_ADDR (default 32'h0000_1008).
  - Extra outputs console_valid_o (1) and console_char_o (8).
  - A RUN-state store to CONSOLE_ADDR pulses console_valid_o for exactly one cycle, registered one cycle after the store, with console_char_o=dmem_wdata_i[7:0].
  - Both console outputs are 0 on reset and in all non-RUN states.
- Without it: the ports and parameter do not exist, and console-address stores are ignored like any other non-tohost store.

Decomposition:
- Package test_monitor_pkg holds:
  - typedef enum logic [2:0] state_t {ST_RST, ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT}.
  - Default address localparams TOHOST_ADDR_DEF and CONSOLE_ADDR_DEF.
- One sub-module, sat_counter (params W; ports clk_i, rst_i, clr_i, inc_i, cnt_o).
  - Synchronous active-low reset; clr_i is synchronous.
  - Increment saturates at all-ones.
  - Instantiated twice: cycle count and instret.

Test Plan (RST_CYCLES=2, TIMEOUT_CYCLES=100, TOHOST_ADDR=32'h1000):
- Release rst_i -> core_rst_o high for exactly 2 edges after release, then 0; state_o=ST_RUN; cycle_count_o counts 0,1,2…
- In RUN, drive retire_i on 10 cycles, then store 32'h1 to 32'h1000 at cycle 20 -> done_o=1, pass_o=1, fail_code_o=0, instret_o=10, cycle_count_o=20, core_rst_o=1.
- Store 32'h7 to 32'h1000 -> FAIL, fail_code_o=3, pass_o=0; an earlier store of 32'h4 to 32'h1000 is ignored and stays in RUN.
- No stores -> ST_TIMEOUT with timeout_o=1, cycle_count_o=99; a store of 32'h1 to 32'h1000 exactly at cycle 99 -> PASS instead.
- From PASS, pulse restart_i -> all outputs cleared, 2 reset cycles, RUN again; restart_i pulsed mid-RUN -> no effect. rst_i low mid-RUN -> reset values next edge.
- With TEST_MONITOR_CONSOLE_EN, store 32'h41 to 32'h1008 -> console_valid_o single-cycle pulse with console_char_o=8'h41; the test continues in RUN.
